disp_fbread_ctrl: RTL

//  Frame-buffer read sequencer for the display pipeline. On each VSYNC falling edge it latches DISPON/DISPADDR

---
 rtl/disp_pkg.sv | 17 +
 rtl/disp_vsync_sync.sv | 18 +
 rtl/disp_fbread_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the display frame-buffer read path.
package disp_pkg;
  localparam int H_PIX_DEF        = 640;
  localparam int V_LINES_DEF      = 480;
  localparam int BURST_LEN_DEF    = 16;
  localparam int FIFO_AW_DEF      = 10;
  localparam int FRAME_BEATS      = H_PIX_DEF * V_LINES_DEF;
  localparam int BURSTS_PER_FRAME = FRAME_BEATS / BURST_LEN_DEF;
  localparam int ADDR_ALIGN       = 6;
  localparam int FB_AW            = 29;

  typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, DRAIN} state_t;

  function automatic int bursts_per_frame(input int h, input int v, input int b);
    return (h * v) / b;
  endfunction
endpackage

// File: rtl/disp_vsync_sync.sv
// Three-flop synchroniser for an active-low VSYNC plus a one-cycle falling-edge pulse.
module disp_vsync_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_x,
  output logic vs_fall
);
  logic [2:0] s_q, s_d;

  always_comb s_d = {s_q[1:0], vsync_x};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_q <= '0;
    else        s_q <= s_d;
  end

  assign vs_fall = s_q[2] & ~s_q[1];
endmodule

// File: rtl/disp_fbread_ctrl.sv
// Frame-buffer read sequencer: one AXI INCR burst at a time, gated by FIFO room, restarted by VSYNC.
module disp_fbread_ctrl import disp_pkg::*; #(
  parameter int H_PIX     = H_PIX_DEF,
  parameter int V_LINES   = V_LINES_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int FIFO_AW   = FIFO_AW_DEF
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               DSP_VSYNC_X,
  input  logic               DISPON,
  input  logic [28:0]        DISPADDR,
  input  logic [FIFO_AW:0]   FIFO_FREE,
  output logic               FIFO_WR,
  output logic [31:0]        FIFO_WDATA,
  output logic [31:0]        ARADDR,
  output logic [7:0]         ARLEN,
  output logic               ARVALID,
  input  logic               ARREADY,
  input  logic [31:0]        RDATA,
  input  logic               RLAST,
  input  logic               RVALID,
  output logic               RREADY,
  output logic               FRAME_BUSY
);
  localparam int BPF = bursts_per_frame(H_PIX, V_LINES, BURST_LEN);
  localparam int CW  = $clog2(BPF + 1);
  localparam logic [CW-1:0]    LAST_CNT    = CW'(BPF - 1);
  localparam logic [FB_AW-1:0] BURST_BYTES = FB_AW'(BURST_LEN * 4);
  localparam logic [FIFO_AW:0] BL_FREE     = (FIFO_AW + 1)'(BURST_LEN);

  state_t             state_q, state_d;
  logic [FB_AW-1:0]   base_q, base_d, araddr_q, araddr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               restart_q, restart_d, drain_pend_q, drain_pend_d;
  logic               arvalid_q, arvalid_d, rready_q, rready_d, busy_q, busy_d;
  logic               vs_fall, burst_end;
  logic               unused_addr_lsb;

  disp_vsync_sync u_vs (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .vsync_x (DSP_VSYNC_X),
    .vs_fall (vs_fall)
  );

  assign burst_end       = RVALID & RLAST;
  assign unused_addr_lsb = ^DISPADDR[ADDR_ALIGN-1:0];

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    araddr_d     = araddr_q;
    restart_d    = restart_q;
    drain_pend_d = drain_pend_q;
    // A new VSYNC always resets the frame position; base only moves when enabled.
    if (vs_fall) begin
      cnt_d     = '0;
      restart_d = DISPON;
      if (DISPON) base_d = {DISPADDR[FB_AW-1:ADDR_ALIGN], {ADDR_ALIGN{1'b0}}};
    end
    case (state_q)
      IDLE:  if (vs_fall && DISPON) state_d = REQ;
      REQ: begin
        if (vs_fall) state_d = DISPON ? REQ : IDLE;
        else if (FIFO_FREE >= BL_FREE) begin
          state_d  = ADDR;
          araddr_d = base_q + FB_AW'(cnt_q) * BURST_BYTES;
        end
      end
      ADDR: begin
        if (vs_fall) drain_pend_d = 1'b1;
        if (ARREADY) begin
          drain_pend_d = 1'b0;
          state_d      = (vs_fall || drain_pend_q) ? DRAIN : DATA;
        end
      end
      DATA: begin
        // A VSYNC landing on the last beat leaves nothing to drain.
        if (vs_fall)        state_d = !burst_end ? DRAIN : (DISPON ? REQ : IDLE);
        else if (burst_end) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == LAST_CNT || !DISPON) ? IDLE : REQ;
        end
      end
      DRAIN: if (burst_end) state_d = restart_d ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
    arvalid_d = (state_d == ADDR);
    rready_d  = (state_d inside {DATA, DRAIN});
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= IDLE;
      base_q       <= '0;
      cnt_q        <= '0;
      araddr_q     <= '0;
      restart_q    <= 1'b0;
      drain_pend_q <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      araddr_q     <= araddr_d;
      restart_q    <= restart_d;
      drain_pend_q <= drain_pend_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      busy_q       <= busy_d;
    end
  end

  assign ARADDR     = {3'b000, araddr_q};
  assign ARLEN      = 8'(BURST_LEN - 1);
  assign ARVALID    = arvalid_q;
  assign RREADY     = rready_q;
  assign FRAME_BUSY = busy_q;
  assign FIFO_WR    = (state_q == DATA) & RVALID & ~vs_fall;
  assign FIFO_WDATA = (state_q == DATA) ? RDATA : '0;
endmodule
